// File: rtl/bp_pkg.sv
// Shared types and constants for the speculative branch predictor.
// The counter-training helper is used by the gshare table in bp_spec_unit.
package bp_pkg;

   typedef enum logic [2:0] {
      BP_NONE     = 3'd0,
      BP_COND     = 3'd1,
      BP_UNCOND   = 3'd2,
      BP_CALL     = 3'd3,
      BP_RET      = 3'd4,
      BP_INDIRECT = 3'd5
   } bp_kind_e;

   localparam logic [1:0] CTR_RESET = 2'b01;
   localparam logic [1:0] CTR_MAX   = 2'b11;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
      end
      return (ctr == 2'b00) ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/ras_circ.sv
// Circular return-address stack with checkpoint restore.
// The oldest entry is overwritten when a push arrives at full depth.
module ras_circ #(
   parameter  int RAS_DEPTH = 16,
   localparam int RW        = $clog2(RAS_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [63:0]   push_data_i,
   input  logic          restore_i,
   input  logic [RW-1:0] restore_tos_i,
   input  logic [RW:0]   restore_cnt_i,
   input  logic [63:0]   restore_entry_i,
   output logic [63:0]   top_o,
   output logic [RW-1:0] tos_o,
   output logic [RW:0]   cnt_o,
   output logic [63:0]   next_entry_o
);
   import bp_pkg::*;

   logic [63:0]   mem_q [RAS_DEPTH];
   logic [RW-1:0] tos_q, tos_d, base_tos;
   logic [RW:0]   cnt_q, cnt_d, base_cnt;
   logic          wr_en;
   logic [RW-1:0] wr_idx;
   logic [63:0]   wr_data;

   // A restore rewinds first; a push or pop in the same cycle then acts on the
   // rewound stack, and the push write wins over the restored slot.
   always_comb begin
      base_tos = restore_i ? restore_tos_i : tos_q;
      base_cnt = restore_i ? restore_cnt_i : cnt_q;
      tos_d    = base_tos;
      cnt_d    = base_cnt;
      wr_en    = restore_i;
      wr_idx   = restore_tos_i + RW'(1);
      wr_data  = restore_entry_i;
      if (push_i) begin
         tos_d   = base_tos + RW'(1);
         cnt_d   = (base_cnt == (RW+1)'(RAS_DEPTH)) ? base_cnt : base_cnt + (RW+1)'(1);
         wr_en   = 1'b1;
         wr_idx  = base_tos + RW'(1);
         wr_data = push_data_i;
      end else if (pop_i && (base_cnt != '0)) begin
         tos_d = base_tos - RW'(1);
         cnt_d = base_cnt - (RW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tos_q <= '0;
         cnt_q <= '0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign top_o        = mem_q[tos_q];
   assign tos_o        = tos_q;
   assign cnt_o        = cnt_q;
   assign next_entry_o = mem_q[tos_q + RW'(1)];

endmodule

// File: rtl/bp_spec_unit.sv
// Speculative branch predictor: gshare PHT, global history, circular RAS and
// per-branch checkpoints for exact recovery on mispredict.
module bp_spec_unit
   import bp_pkg::*;
#(
   parameter  int RAS_DEPTH = 16,
   parameter  int GHR_W     = 12,
   parameter  int NCKPT     = 8,
   localparam int CK_W      = $clog2(NCKPT),
   localparam int RW        = $clog2(RAS_DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [63:0]     req_pc_i,
   input  logic [2:0]      req_kind_i,
   input  logic [63:0]     req_direct_tgt_i,
   input  logic [63:0]     req_ind_tgt_i,
   output logic            rsp_valid_o,
   output logic            rsp_taken_o,
   output logic [63:0]     rsp_target_o,
   output logic [CK_W-1:0] rsp_ckpt_o,
   input  logic            resolve_valid_i,
   input  logic            resolve_mispredict_i,
   input  logic            resolve_taken_i,
   input  logic [CK_W-1:0] resolve_ckpt_i,
   input  logic            commit_valid_i,
   input  logic            commit_taken_i
);

   bp_kind_e        req_kind;
   logic            accept, alloc, mispredict, commit_ok;
   logic [63:0]     pc_plus4;
   logic [GHR_W-1:0] ghr_q, ghr_d, pht_ridx, pht_widx;
   logic [1:0]      pht_q [2**GHR_W];
   logic            pht_we;
   logic [1:0]      pht_wdata;

   bp_kind_e        ck_kind_q [NCKPT];
   logic [63:0]     ck_pc_q   [NCKPT];
   logic [GHR_W-1:0] ck_ghr_q [NCKPT];
   logic [RW-1:0]   ck_tos_q  [NCKPT];
   logic [RW:0]     ck_cnt_q  [NCKPT];
   logic [63:0]     ck_ent_q  [NCKPT];

   logic [CK_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CK_W:0]   cnt_q, cnt_d, cnt_base;

   logic            rsp_valid_q, rsp_valid_d, rsp_taken_q, rsp_taken_d;
   logic [63:0]     rsp_target_q, rsp_target_d;
   logic [CK_W-1:0] rsp_ckpt_q, rsp_ckpt_d;

   logic            ras_push, ras_pop;
   logic [63:0]     ras_push_data, ras_top, ras_next;
   logic [RW-1:0]   ras_tos;
   logic [RW:0]     ras_cnt;

   assign mispredict  = resolve_valid_i && resolve_mispredict_i;
   assign req_ready_o = (cnt_q < (CK_W+1)'(NCKPT)) && !mispredict;

   always_comb begin
      req_kind      = bp_kind_e'(req_kind_i);
      accept        = req_valid_i && req_ready_o;
      alloc         = accept && (req_kind != BP_NONE);
      commit_ok     = commit_valid_i && (cnt_q != '0);
      pc_plus4      = req_pc_i + 64'd4;
      pht_ridx      = req_pc_i[GHR_W+1:2] ^ ghr_q;
      rsp_valid_d   = accept;
      rsp_taken_d   = rsp_taken_q;
      rsp_target_d  = rsp_target_q;
      rsp_ckpt_d    = rsp_ckpt_q;
      ghr_d         = ghr_q;
      ras_push      = 1'b0;
      ras_pop       = 1'b0;
      ras_push_data = pc_plus4;
      if (accept) begin
         rsp_taken_d  = 1'b1;
         rsp_target_d = req_direct_tgt_i;
         rsp_ckpt_d   = tail_q;
         case (req_kind)
            BP_COND: begin
               rsp_taken_d = pht_q[pht_ridx][1];
               if (!pht_q[pht_ridx][1]) rsp_target_d = pc_plus4;
               ghr_d = {ghr_q[GHR_W-2:0], pht_q[pht_ridx][1]};
            end
            BP_CALL:     ras_push = 1'b1;
            BP_RET: begin
               if (ras_cnt != '0) begin
                  rsp_target_d = ras_top;
                  ras_pop      = 1'b1;
               end else begin
                  rsp_taken_d  = 1'b0;
                  rsp_target_d = pc_plus4;
               end
            end
            BP_INDIRECT: rsp_target_d = req_ind_tgt_i;
            BP_UNCOND:   ;
            default: begin
               rsp_taken_d  = 1'b0;
               rsp_target_d = pc_plus4;
            end
         endcase
      end
      // Recovery rewinds to the checkpoint and replays the branch's own effect.
      if (mispredict) begin
         ghr_d         = (ck_kind_q[resolve_ckpt_i] == BP_COND) ?
                         {ck_ghr_q[resolve_ckpt_i][GHR_W-2:0], resolve_taken_i} :
                         ck_ghr_q[resolve_ckpt_i];
         ras_push      = (ck_kind_q[resolve_ckpt_i] == BP_CALL);
         ras_pop       = (ck_kind_q[resolve_ckpt_i] == BP_RET);
         ras_push_data = ck_pc_q[resolve_ckpt_i] + 64'd4;
         tail_d        = resolve_ckpt_i + CK_W'(1);
         cnt_base      = {1'b0, resolve_ckpt_i - head_q} + (CK_W+1)'(1);
      end else begin
         tail_d   = tail_q + CK_W'(alloc);
         cnt_base = cnt_q + (CK_W+1)'(alloc);
      end
      head_d    = head_q + CK_W'(commit_ok);
      cnt_d     = cnt_base - (CK_W+1)'(commit_ok);
      pht_widx  = ck_pc_q[head_q][GHR_W+1:2] ^ ck_ghr_q[head_q];
      pht_we    = commit_ok && (ck_kind_q[head_q] == BP_COND);
      pht_wdata = ctr_train(pht_q[pht_widx], commit_taken_i);
   end

   ras_circ #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk             (clk),
      .rst             (rst),
      .push_i          (ras_push),
      .pop_i           (ras_pop),
      .push_data_i     (ras_push_data),
      .restore_i       (mispredict),
      .restore_tos_i   (ck_tos_q[resolve_ckpt_i]),
      .restore_cnt_i   (ck_cnt_q[resolve_ckpt_i]),
      .restore_entry_i (ck_ent_q[resolve_ckpt_i]),
      .top_o           (ras_top),
      .tos_o           (ras_tos),
      .cnt_o           (ras_cnt),
      .next_entry_o    (ras_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q        <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_taken_q  <= 1'b0;
         rsp_target_q <= '0;
         rsp_ckpt_q   <= '0;
         for (int i = 0; i < 2**GHR_W; i++) pht_q[i] <= CTR_RESET;
      end else begin
         ghr_q        <= ghr_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_taken_q  <= rsp_taken_d;
         rsp_target_q <= rsp_target_d;
         rsp_ckpt_q   <= rsp_ckpt_d;
         if (pht_we) pht_q[pht_widx] <= pht_wdata;
      end
   end

   // Checkpoint payload holds pre-operation state; validity comes from head/tail.
   always_ff @(posedge clk) begin
      if (alloc) begin
         ck_kind_q[tail_q] <= req_kind;
         ck_pc_q[tail_q]   <= req_pc_i;
         ck_ghr_q[tail_q]  <= ghr_q;
         ck_tos_q[tail_q]  <= ras_tos;
         ck_cnt_q[tail_q]  <= ras_cnt;
         ck_ent_q[tail_q]  <= ras_next;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_taken_o  = rsp_taken_q;
   assign rsp_target_o = rsp_target_q;
   assign rsp_ckpt_o   = rsp_ckpt_q;

endmodule

// File: tb/tb_bp_spec_unit.sv
// Bench for bp_spec_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_bp_spec_unit;
   localparam int RAS_DEPTH = 16;
   localparam int GHR_W     = 12;
   localparam int NCKPT     = 8;
   localparam int CK_W      = 3;
   localparam int GMASK     = (1 << GHR_W) - 1;
   localparam logic [2:0] K_NONE = 3'd0, K_COND = 3'd1, K_UNCOND = 3'd2,
                          K_CALL = 3'd3, K_RET = 3'd4, K_IND = 3'd5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid, req_ready_o;
   logic [63:0]     req_pc, req_dt, req_it;
   logic [2:0]      req_kind;
   logic            rsp_valid_o, rsp_taken_o;
   logic [63:0]     rsp_target_o;
   logic [CK_W-1:0] rsp_ckpt_o;
   logic            resolve_valid, resolve_mis, resolve_taken;
   logic [CK_W-1:0] resolve_ckpt;
   logic            commit_valid, commit_taken;

   bp_spec_unit #(.RAS_DEPTH(RAS_DEPTH), .GHR_W(GHR_W), .NCKPT(NCKPT)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_pc_i(req_pc),
      .req_kind_i(req_kind), .req_direct_tgt_i(req_dt), .req_ind_tgt_i(req_it),
      .rsp_valid_o(rsp_valid_o), .rsp_taken_o(rsp_taken_o),
      .rsp_target_o(rsp_target_o), .rsp_ckpt_o(rsp_ckpt_o),
      .resolve_valid_i(resolve_valid), .resolve_mispredict_i(resolve_mis),
      .resolve_taken_i(resolve_taken), .resolve_ckpt_i(resolve_ckpt),
      .commit_valid_i(commit_valid), .commit_taken_i(commit_taken)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          kind;
      logic [63:0] pc;
      int          ghr;
      int          tos;
      int          cnt;
      logic [63:0] ent;
   } ck_t;

   int          m_ghr, m_tos, m_cnt, m_head, m_tail;
   logic [1:0]  m_pht [1 << GHR_W];
   logic [63:0] m_ras [RAS_DEPTH];
   ck_t         m_ck[$];
   logic        e_valid, e_taken, e_ready, e_alloc;
   logic [63:0] e_target;
   int          e_ckpt;

   task automatic model_reset();
      m_ghr = 0; m_tos = 0; m_cnt = 0; m_head = 0; m_tail = 0;
      foreach (m_pht[i]) m_pht[i] = 2'b01;
      m_ck.delete();
      e_valid = 0; e_taken = 0; e_target = '0; e_ckpt = 0; e_alloc = 0;
   endtask

   task automatic ras_push(input logic [63:0] v);
      m_tos = (m_tos + 1) % RAS_DEPTH;
      m_ras[m_tos] = v;
      if (m_cnt < RAS_DEPTH) m_cnt++;
   endtask

   task automatic ras_pop();
      if (m_cnt > 0) begin
         m_tos = (m_tos + RAS_DEPTH - 1) % RAS_DEPTH;
         m_cnt--;
      end
   endtask

   task automatic model_step();
      ck_t e;
      int  pos, idx;
      bit  acc, mis, cm;
      mis     = resolve_valid && resolve_mis;
      e_ready = (m_ck.size() < NCKPT) && !mis;
      acc     = req_valid && e_ready;
      cm      = commit_valid && (m_ck.size() > 0);
      e_valid = acc;
      e_alloc = acc && (req_kind != K_NONE);
      if (acc) begin
         e_ckpt = m_tail;
         e.kind = int'(req_kind); e.pc = req_pc; e.ghr = m_ghr;
         e.tos = m_tos; e.cnt = m_cnt; e.ent = m_ras[(m_tos + 1) % RAS_DEPTH];
         e_taken = 1; e_target = req_dt;
         case (req_kind)
            K_COND: begin
               idx = int'((req_pc >> 2) & 64'(GMASK)) ^ m_ghr;
               e_taken = m_pht[idx][1];
               if (!e_taken) e_target = req_pc + 4;
               m_ghr = ((m_ghr << 1) | int'(e_taken)) & GMASK;
            end
            K_CALL: ras_push(req_pc + 4);
            K_RET: begin
               if (m_cnt > 0) begin
                  e_target = m_ras[m_tos];
                  ras_pop();
               end else begin
                  e_taken = 0; e_target = req_pc + 4;
               end
            end
            K_IND: e_target = req_it;
            K_UNCOND: ;
            default: begin e_taken = 0; e_target = req_pc + 4; end
         endcase
         if (req_kind != K_NONE) begin
            m_ck.push_back(e);
            m_tail = (m_tail + 1) % NCKPT;
         end
      end
      if (mis) begin
         pos = (int'(resolve_ckpt) - m_head + NCKPT) % NCKPT;
         e = m_ck[pos];
         while (m_ck.size() > pos + 1) void'(m_ck.pop_back());
         m_tail = (int'(resolve_ckpt) + 1) % NCKPT;
         m_ghr = e.ghr; m_tos = e.tos; m_cnt = e.cnt;
         m_ras[(m_tos + 1) % RAS_DEPTH] = e.ent;
         if (e.kind == 1) m_ghr = ((m_ghr << 1) | int'(resolve_taken)) & GMASK;
         else if (e.kind == 3) ras_push(e.pc + 4);
         else if (e.kind == 4) ras_pop();
      end
      if (cm) begin
         e = m_ck.pop_front();
         m_head = (m_head + 1) % NCKPT;
         if (e.kind == 1) begin
            idx = int'((e.pc >> 2) & 64'(GMASK)) ^ e.ghr;
            if (commit_taken && m_pht[idx] != 2'b11) m_pht[idx]++;
            else if (!commit_taken && m_pht[idx] != 2'b00) m_pht[idx]--;
         end
      end
   endtask

   // ---------------- drive / compare ----------------
   task automatic idle();
      req_valid = 0; req_kind = K_NONE; req_pc = '0; req_dt = '0; req_it = '0;
      resolve_valid = 0; resolve_mis = 0; resolve_taken = 0; resolve_ckpt = '0;
      commit_valid = 0; commit_taken = 0;
   endtask

   task automatic set_req(input logic [2:0] k, input logic [63:0] pc, input logic [63:0] dt);
      req_valid = 1; req_kind = k; req_pc = pc; req_dt = dt; req_it = 64'hDEAD_0000;
   endtask

   task automatic cycle();
      #1;
      assert (!(commit_valid && m_ck.size() == 0)) else $error("commit issued with no checkpoint in flight");
      model_step();
      chk("req_ready", 64'(req_ready_o), 64'(e_ready));
      @(posedge clk);
      #1;
      chk("rsp_valid", 64'(rsp_valid_o), 64'(e_valid));
      if (e_valid) begin
         chk("rsp_taken", 64'(rsp_taken_o), 64'(e_taken));
         chk("rsp_target", rsp_target_o, e_target);
         if (e_alloc) chk("rsp_ckpt", 64'(rsp_ckpt_o), 64'(e_ckpt));
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1;
      idle();
      #1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      idle();
      foreach (m_ras[i]) m_ras[i] = '0;
      do_reset();
      chk("reset_valid", 64'(rsp_valid_o), 0);
      chk("reset_taken", 64'(rsp_taken_o), 0);
      chk("reset_target", rsp_target_o, 0);
      chk("reset_ckpt", 64'(rsp_ckpt_o), 0);
      chk("reset_ready", 64'(req_ready_o), 1);

      // First conditional after reset: weakly not-taken.
      set_req(K_COND, 64'h1000, 64'h2000);
      cycle();
      chk("cond0_taken", 64'(rsp_taken_o), 0);
      chk("cond0_target", rsp_target_o, 64'h1004);
      chk("cond0_ckpt", 64'(rsp_ckpt_o), 0);

      // Two taken commits saturate the counter toward taken.
      do_reset();
      set_req(K_COND, 64'h1000, 64'h2000); cycle();
      set_req(K_COND, 64'h1000, 64'h2000); cycle();
      idle(); commit_valid = 1; commit_taken = 1; cycle(); cycle();
      idle(); set_req(K_COND, 64'h1000, 64'h2000); cycle();
      chk("trained_taken", 64'(rsp_taken_o), 1);
      chk("trained_target", rsp_target_o, 64'h2000);

      // Calls and returns.
      do_reset();
      set_req(K_CALL, 64'h100, 64'hA00); cycle();
      set_req(K_CALL, 64'h200, 64'hB00); cycle();
      set_req(K_RET, 64'h300, 64'h0); cycle();
      chk("ret1_target", rsp_target_o, 64'h204);
      cycle();
      chk("ret2_target", rsp_target_o, 64'h104);
      cycle();
      chk("ret3_taken", 64'(rsp_taken_o), 0);
      chk("ret3_target", rsp_target_o, 64'h304);

      // Overflow: 17 calls overwrite the oldest return.
      do_reset();
      for (int i = 0; i <= RAS_DEPTH; i++) begin
         idle(); set_req(K_CALL, 64'(i * 16), 64'hF00);
         commit_valid = (i > 0);
         cycle();
      end
      for (int j = 0; j <= RAS_DEPTH; j++) begin
         idle(); set_req(K_RET, 64'h900, 64'h0); commit_valid = 1;
         cycle();
         if (j == 0) chk("ovf_first_ret", rsp_target_o, 64'h104);
         if (j == RAS_DEPTH - 1) chk("ovf_last_ret", rsp_target_o, 64'h14);
         if (j == RAS_DEPTH) chk("ovf_empty_taken", 64'(rsp_taken_o), 0);
      end

      // Wrong-path push after a RET is repaired by the mispredict.
      do_reset();
      set_req(K_CALL, 64'h100, 64'hA00); cycle();
      set_req(K_CALL, 64'h200, 64'hB00); cycle();
      set_req(K_RET, 64'h400, 64'h0); cycle();
      chk("rep_ret_target", rsp_target_o, 64'h204);
      chk("rep_ret_ckpt", 64'(rsp_ckpt_o), 2);
      set_req(K_CALL, 64'h500, 64'hC00); cycle();
      idle(); resolve_valid = 1; resolve_mis = 1; resolve_taken = 1; resolve_ckpt = 3'd2; cycle();
      idle(); set_req(K_RET, 64'h400, 64'h0); cycle();
      chk("rep_next_ret", rsp_target_o, 64'h104);

      // GHR repair with a same-cycle commit of the resolved head.
      do_reset();
      set_req(K_COND, 64'h1000, 64'h2000); cycle();
      idle(); resolve_valid = 1; resolve_mis = 1; resolve_taken = 1; resolve_ckpt = 3'd0;
      commit_valid = 1; commit_taken = 1; cycle();
      idle(); set_req(K_COND, 64'h1004, 64'h3000); cycle();
      chk("ghr_rep_taken", 64'(rsp_taken_o), 1);
      chk("ghr_rep_target", rsp_target_o, 64'h3000);

      // Checkpoint ring full, commit, then asynchronous reset mid-stream.
      do_reset();
      for (int k = 0; k < NCKPT; k++) begin
         set_req(K_UNCOND, 64'(k * 64), 64'h7000); cycle();
      end
      set_req(K_UNCOND, 64'h800, 64'h7100); commit_valid = 1;
      #1 chk("full_ready", 64'(req_ready_o), 0);
      cycle();
      idle(); set_req(K_UNCOND, 64'h900, 64'h7200);
      #1 chk("ready_after_commit", 64'(req_ready_o), 1);
      cycle();
      idle();
      rst = 1;
      #1;
      chk("async_rst_valid", 64'(rsp_valid_o), 0);
      chk("async_rst_taken", 64'(rsp_taken_o), 0);
      chk("async_rst_target", rsp_target_o, 0);
      chk("async_rst_ckpt", 64'(rsp_ckpt_o), 0);
      chk("async_rst_ready", 64'(req_ready_o), 1);
      do_reset();

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         if (n == 2000) do_reset();
         idle();
         if ($urandom_range(3, 0) != 0) begin
            req_valid = 1;
            req_kind  = 3'($urandom_range(5, 0));
            req_pc    = 64'h1000 + 64'($urandom_range(31, 0)) * 4;
            req_dt    = {$urandom, $urandom};
            req_it    = {$urandom, $urandom};
         end
         if (m_ck.size() > 0 && $urandom_range(7, 0) == 0) begin
            resolve_valid = 1;
            resolve_mis   = 1'($urandom_range(1, 0));
            resolve_taken = 1'($urandom_range(1, 0));
            resolve_ckpt  = 3'((m_head + int'($urandom_range(m_ck.size() - 1, 0))) % NCKPT);
         end
         if (m_ck.size() > 0 && $urandom_range(2, 0) == 0) begin
            commit_valid = 1;
            commit_taken = 1'($urandom_range(1, 0));
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
